// File: rtl/regfile_sched_pkg.sv
// Shared types and helpers for the register-file access scheduler.
// req_t fields follow the default widths; the top's width parameters default to the same values.
package regfile_sched_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 5;
    localparam int MAX_REQ   = 8;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] wdata;
    } req_t;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr whose
// mask bit is set.
module rr_arbiter
    import regfile_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         mask,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    logic [N-1:0] cand;

    assign cand = req & mask;
    assign any  = |cand;

    always_comb begin
        int j;
        gnt = '0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (gnt == '0 && cand[j]) gnt[j] = 1'b1;
        end
    end

    assign idx = $clog2(N)'(onehot_to_idx(MAX_REQ'(gnt)));

endmodule

// File: rtl/regfile_access_sched.sv
// Schedules NUM_REQ requesters onto a 2-read/1-write register file with
// round-robin fairness, write-before-read hazard retry and read anti-starvation.
module regfile_access_sched
    import regfile_sched_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int NUM_REQ    = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [DATA_WIDTH-1:0]            rsp_rdata2,
    output logic [NUM_REQ-1:0]               rsp_port,
    output logic                             rf_wen,
    output logic [ADDR_WIDTH-1:0]            rf_wad,
    output logic [DATA_WIDTH-1:0]            rf_din,
    output logic                             rf_ren1,
    output logic [ADDR_WIDTH-1:0]            rf_rad1,
    output logic                             rf_ren2,
    output logic [ADDR_WIDTH-1:0]            rf_rad2,
    input  logic [DATA_WIDTH-1:0]            rf_dout1,
    input  logic [DATA_WIDTH-1:0]            rf_dout2
);

    localparam int IW = $clog2(NUM_REQ);

    req_t               req_s [NUM_REQ];
    logic [NUM_REQ-1:0] wr_elig, hazard_vec, rd_elig, rd2_elig;
    logic [NUM_REQ-1:0] wr_gnt, rd1_gnt, rd2_gnt;
    logic [IW-1:0]      wr_idx, rd1_idx, rd2_idx;
    logic               wr_any, rd1_any, rd2_any;
    logic               hazard, blk_clear;

    logic [IW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [NUM_REQ-1:0]    tag1_reg, tag2_reg;
    logic                  blk_valid_reg;
    logic [ADDR_WIDTH-1:0] blk_addr_reg;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Eligibility is gated by resetn so nothing is granted while in reset.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_s[gi] = '{we:    req_we[gi],
                                 addr:  req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH],
                                 wdata: req_wdata[gi*DATA_WIDTH +: DATA_WIDTH]};
            assign wr_elig[gi]    = resetn & req_valid[gi] & req_s[gi].we &
                                    !(blk_valid_reg && req_s[gi].addr == blk_addr_reg);
            assign hazard_vec[gi] = resetn & req_valid[gi] & !req_s[gi].we &
                                    wr_any & (req_s[gi].addr == rf_wad);
            assign rd_elig[gi]    = resetn & req_valid[gi] & !req_s[gi].we & !hazard_vec[gi];
            assign rd2_elig[gi]   = rd_elig[gi] & !(rd1_any && req_s[gi].addr == rf_rad1);
        end
    endgenerate

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .req(wr_elig), .ptr(wr_ptr_reg), .mask({NUM_REQ{1'b1}}),
        .gnt(wr_gnt), .idx(wr_idx), .any(wr_any)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd1_arb (
        .req(rd_elig), .ptr(rd_ptr_reg), .mask({NUM_REQ{1'b1}}),
        .gnt(rd1_gnt), .idx(rd1_idx), .any(rd1_any)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd2_arb (
        .req(rd2_elig), .ptr(rd_ptr_reg), .mask(~rd1_gnt),
        .gnt(rd2_gnt), .idx(rd2_idx), .any(rd2_any)
    );

    assign rf_wen  = wr_any;
    assign rf_wad  = wr_any  ? req_s[wr_idx].addr  : '0;
    assign rf_din  = wr_any  ? req_s[wr_idx].wdata : '0;
    assign rf_ren1 = rd1_any;
    assign rf_rad1 = rd1_any ? req_s[rd1_idx].addr : '0;
    assign rf_ren2 = rd2_any;
    assign rf_rad2 = rd2_any ? req_s[rd2_idx].addr : '0;

    assign req_ready  = wr_gnt | rd1_gnt | rd2_gnt;
    assign rsp_valid  = tag1_reg | tag2_reg;
    assign rsp_port   = tag2_reg;
    assign rsp_rdata  = rf_dout1;
    assign rsp_rdata2 = rf_dout2;

    // Every excluded reader shares the write address, so rf_wad is the blocked address.
    assign hazard    = |hazard_vec;
    assign blk_clear = blk_valid_reg &&
                       ((rd1_any && rf_rad1 == blk_addr_reg) || (rd2_any && rf_rad2 == blk_addr_reg));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            tag1_reg      <= '0;
            tag2_reg      <= '0;
            blk_valid_reg <= 1'b0;
            blk_addr_reg  <= '0;
        end else begin
            if (wr_any) wr_ptr_reg <= ptr_inc(wr_idx);
            if (rd2_any)      rd_ptr_reg <= ptr_inc(rd2_idx);
            else if (rd1_any) rd_ptr_reg <= ptr_inc(rd1_idx);
            tag1_reg <= rd1_gnt;
            tag2_reg <= rd2_gnt;
            if (hazard && (!blk_valid_reg || blk_clear)) begin
                blk_valid_reg <= 1'b1;
                blk_addr_reg  <= rf_wad;
            end else if (blk_clear) begin
                blk_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_sched.sv
// Directed bench for regfile_access_sched with a behavioural 2R/1W register file.
module tb_regfile_access_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [3:0]  req_valid = '0, req_we = '0;
    logic [19:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_ready, rsp_valid, rsp_port;
    logic [15:0] rsp_rdata, rsp_rdata2, rf_din, rf_dout1, rf_dout2;
    logic        rf_wen, rf_ren1, rf_ren2;
    logic [4:0]  rf_wad, rf_rad1, rf_rad2;
    logic [15:0] mem [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_access_sched dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_rdata2(rsp_rdata2), .rsp_port(rsp_port),
        .rf_wen(rf_wen), .rf_wad(rf_wad), .rf_din(rf_din),
        .rf_ren1(rf_ren1), .rf_rad1(rf_rad1), .rf_ren2(rf_ren2), .rf_rad2(rf_rad2),
        .rf_dout1(rf_dout1), .rf_dout2(rf_dout2)
    );

    always @(posedge clk) begin
        if (rf_wen)  mem[rf_wad] <= rf_din;
        if (rf_ren1) rf_dout1 <= mem[rf_rad1];
        if (rf_ren2) rf_dout2 <= mem[rf_rad2];
    end

    always @(posedge clk) begin
        if (resetn && (|req_ready || |rsp_valid))
            $display("t=%0t ready=%b wen=%b wad=%0d ren1=%b rad1=%0d ren2=%b rad2=%0d rsp_valid=%b rsp_port=%b rdata=%h rdata2=%h",
                     $time, req_ready, rf_wen, rf_wad, rf_ren1, rf_rad1, rf_ren2, rf_rad2,
                     rsp_valid, rsp_port, rsp_rdata, rsp_rdata2);
    end

    // Read-port invariants hold on every cycle.
    always @(negedge clk) begin
        if (resetn) begin
            checks++;
            if (rf_ren2 && (!rf_ren1 || rf_rad1 == rf_rad2)) begin
                errors++;
                $display("FAIL rd_port_invariant ren1=%b rad1=%0d ren2=%b rad2=%0d required ren1=1 and rad1!=rad2",
                         rf_ren1, rf_rad1, rf_ren2, rf_rad2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [4:0] a, input logic [15:0] d);
        req_valid[i]      = v;
        req_we[i]         = we;
        req_addr[i*5 +: 5]   = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            req_valid = 4'hF;
            req_we    = 4'($urandom_range(0, 15));
            req_addr  = 20'($urandom);
            req_wdata = {$urandom, $urandom};
            settle();
            checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
            checks++; if ({rf_wen, rf_ren1, rf_ren2} !== 3'b0) begin errors++; $display("FAIL reset_rf_en got=%b exp=000", {rf_wen, rf_ren1, rf_ren2}); end
            checks++; if (rsp_valid !== 4'b0 || rsp_port !== 4'b0) begin errors++; $display("FAIL reset_rsp got=%b/%b exp=0000/0000", rsp_valid, rsp_port); end
            checks++; if (rf_wad !== 5'd0 || rf_din !== 16'd0) begin errors++; $display("FAIL reset_rf_addr got=%0d/%h exp=0/0000", rf_wad, rf_din); end
        end
        step();
        set_req(0, 1, 1, 5'd3,  16'h1111);
        set_req(1, 1, 1, 5'd7,  16'h2222);
        set_req(2, 1, 1, 5'd10, 16'hAAAA);
        set_req(3, 1, 1, 5'd11, 16'hBBBB);
        resetn = 1'b1;
        // Writers are consumed one per cycle in pointer order, wrapping back to 0.
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (req_ready !== 4'(1 << k)) begin errors++; $display("FAIL post_reset_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << k)); end
            step();
            req_valid[k] = 1'b0;
        end
        clear_all();
    endtask

    task automatic test_three_reads();
        set_req(0, 1, 0, 5'd3, 16'h0);
        set_req(1, 1, 0, 5'd7, 16'h0);
        set_req(2, 1, 0, 5'd9, 16'h0);
        settle();
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL three_rd_ready_t got=%b exp=0011", req_ready); end
        checks++; if ({rf_ren1, rf_rad1, rf_ren2, rf_rad2} !== {1'b1, 5'd3, 1'b1, 5'd7}) begin errors++; $display("FAIL three_rd_ports got=%b/%0d %b/%0d exp=1/3 1/7", rf_ren1, rf_rad1, rf_ren2, rf_rad2); end
        step();
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        settle();
        checks++; if (rsp_valid !== 4'b0011 || rsp_port !== 4'b0010) begin errors++; $display("FAIL three_rd_rsp got=%b/%b exp=0011/0010", rsp_valid, rsp_port); end
        checks++; if (rsp_rdata !== 16'h1111 || rsp_rdata2 !== 16'h2222) begin errors++; $display("FAIL three_rd_data got=%h/%h exp=1111/2222", rsp_rdata, rsp_rdata2); end
        checks++; if (req_ready !== 4'b0100 || rf_ren2 !== 1'b0) begin errors++; $display("FAIL three_rd_ready_t1 got=%b ren2=%b exp=0100 ren2=0", req_ready, rf_ren2); end
        step();
        clear_all();
        settle();
        checks++; if (rsp_valid !== 4'b0100 || rsp_port !== 4'b0000) begin errors++; $display("FAIL three_rd_rsp_t2 got=%b/%b exp=0100/0000", rsp_valid, rsp_port); end
        step();
    endtask

    task automatic test_hazard();
        set_req(0, 1, 1, 5'd5, 16'hBEEF);
        set_req(1, 1, 0, 5'd5, 16'h0);
        settle();
        checks++; if (req_ready !== 4'b0001 || rf_wen !== 1'b1 || rf_ren1 !== 1'b0) begin errors++; $display("FAIL hazard_t got=%b wen=%b ren1=%b exp=0001 wen=1 ren1=0", req_ready, rf_wen, rf_ren1); end
        step();
        req_valid[0] = 1'b0;
        settle();
        checks++; if (req_ready !== 4'b0010 || rf_ren1 !== 1'b1 || rf_rad1 !== 5'd5) begin errors++; $display("FAIL hazard_t1 got=%b ren1=%b rad1=%0d exp=0010 1 5", req_ready, rf_ren1, rf_rad1); end
        step();
        clear_all();
        settle();
        checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL hazard_t2 got=%b/%h exp=0010/beef", rsp_valid, rsp_rdata); end
        step();
    endtask

    task automatic test_starvation();
        set_req(0, 1, 1, 5'd5, 16'h0A0A);
        set_req(1, 1, 0, 5'd5, 16'h0);
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL starve_t got=%b exp=0001", req_ready); end
        step();
        set_req(0, 1, 1, 5'd5, 16'h0B0B);
        settle();
        checks++; if (req_ready !== 4'b0010 || rf_wen !== 1'b0 || rf_rad1 !== 5'd5) begin errors++; $display("FAIL starve_t1 got=%b wen=%b rad1=%0d exp=0010 0 5", req_ready, rf_wen, rf_rad1); end
        step();
        req_valid[1] = 1'b0;
        settle();
        checks++; if (req_ready !== 4'b0001 || rf_din !== 16'h0B0B) begin errors++; $display("FAIL starve_t2 got=%b din=%h exp=0001 0b0b", req_ready, rf_din); end
        checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'h0A0A) begin errors++; $display("FAIL starve_rsp got=%b/%h exp=0010/0a0a", rsp_valid, rsp_rdata); end
        step();
        clear_all();
    endtask

    task automatic test_dup_addr();
        set_req(3, 1, 1, 5'd4, 16'h4444);
        settle();
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL dup_prewrite got=%b exp=1000", req_ready); end
        step();
        clear_all();
        set_req(1, 1, 0, 5'd4, 16'h0);
        set_req(2, 1, 0, 5'd4, 16'h0);
        settle();
        checks++; if (req_ready !== 4'b0100 || rf_ren2 !== 1'b0) begin errors++; $display("FAIL dup_t got=%b ren2=%b exp=0100 0", req_ready, rf_ren2); end
        step();
        req_valid[2] = 1'b0;
        settle();
        checks++; if (req_ready !== 4'b0010 || rsp_valid !== 4'b0100 || rsp_rdata !== 16'h4444) begin errors++; $display("FAIL dup_t1 got=%b %b %h exp=0010 0100 4444", req_ready, rsp_valid, rsp_rdata); end
        step();
        clear_all();
        settle();
        checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'h4444) begin errors++; $display("FAIL dup_t2 got=%b %h exp=0010 4444", rsp_valid, rsp_rdata); end
        step();
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 4; i++) set_req(i, 1, 1, 5'(16 + i), 16'(i));
        for (int k = 0; k < 8; k++) begin
            settle();
            checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL fair_cycle%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
            step();
        end
        clear_all();
        step();
    endtask

    task automatic test_reset_mid_read();
        set_req(0, 1, 0, 5'd3, 16'h0);
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant got=%b exp=0001", req_ready); end
        step();
        clear_all();
        resetn = 1'b0;
        settle();
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL midrst_drop got=%b exp=0000", rsp_valid); end
        step();
        resetn = 1'b1;
        step();
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL midrst_after got=%b exp=0000", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_three_reads();
        test_hazard();
        test_starvation();
        test_dup_addr();
        test_fairness();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
